fork2_reg: RTL
==============

FORK2_REG -- requirements
Module: fork2_reg

Interface
REQ-001 Parameter: DW, default 1, data width in bits; legal range 1..1024.
REQ-002 Port: CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: RST_N  input  1  reset, asynchronous, active-low.
REQ-004 Port: i_data  input  DW  upstream word.
REQ-005 Port: i_valid  input  1  upstream word present.
REQ-006 Port: i_rdy  output  1  block can accept the upstream word this cycle.
REQ-007 Port: o0_data  output  DW  branch 0 word.
REQ-008 Port: o0_valid  output  1  branch 0 word present.
REQ-009 Port: o0_rdy  input  1  branch 0 consumer accepts.
REQ-010 Port: o1_data  output  DW  branch 1 word.
REQ-011 Port: o1_valid  output  1  branch 1 word present.
REQ-012 Port: o1_rdy  input  1  branch 1 consumer accepts.

Function
REQ-013 Function: registered one-entry eager fork; each accepted word is delivered exactly once to each branch, in order, with branches consuming independently.
REQ-014 Function: state = data register D[DW], flag FULL, flags TK0 and TK1 (branch n has already taken D).
REQ-015 Function: fire_in = i_valid & i_rdy; fire0 = o0_valid & o0_rdy; fire1 = o1_valid & o1_rdy.
REQ-016 Function: o0_valid = FULL & ~TK0; o1_valid = FULL & ~TK1; o0_data = o1_data = D (combinational from registers only).
REQ-017 Function: done = FULL & (TK0 | fire0) & (TK1 | fire1), i.e. the last outstanding branch completes this cycle.
REQ-018 Function: i_rdy = ~FULL | done; i_rdy shall not depend combinationally on i_valid.
REQ-019 Function: latency 1 cycle; a word accepted at edge N is valid on both branches from cycle N+1.
REQ-020 Function: throughput 1 word/cycle when both o0_rdy and o1_rdy are held high.
REQ-021 Function: on fire_in: D <= i_data, FULL <= 1, TK0 <= 0, TK1 <= 0; this takes priority over the done clear in the same cycle (back-to-back refill).
REQ-022 Function: on done without fire_in: FULL <= 0, TK0 <= 0, TK1 <= 0.
REQ-023 Function: otherwise TKn <= TKn | firen, and D and FULL hold.
REQ-024 Function: D shall not change while FULL = 1 and done = 0.
REQ-025 Function: once asserted, o0_valid/o1_valid shall not deassert until the matching branch fires (AXI-style valid stability).
REQ-026 Function: a branch with rdy held low stalls the input indefinitely; the other branch receives the word once and then shows valid = 0 until the next word.
REQ-027 Function: both branches firing in the same cycle is legal and counts as done.

Reset
REQ-028 Reset: while RST_N = 0, FULL = TK0 = TK1 = 0 and D = 0 immediately, without waiting for a clock edge.
REQ-029 Reset: outputs during reset: o0_valid = o1_valid = 0, o0_data = o1_data = 0, i_rdy = 0.
REQ-030 Reset: a word held mid-operation (FULL = 1, partially taken) is discarded by reset; it is not delivered after release.
REQ-031 Reset: the first rising CLK edge after RST_N deasserts with i_valid = 1 accepts a word (i_rdy = 1 in that cycle).

Verification
REQ-032 Verification: DW = 8, o0_rdy = o1_rdy = 1, stream 0x01..0x10 one per cycle -> each branch outputs 0x01..0x10 in order, 1-cycle latency, i_rdy constantly 1.
REQ-033 Verification: send 0xA5, o0_rdy = 1, o1_rdy = 0 for 5 cycles -> o0 takes 0xA5 once, o0_valid = 0 afterwards, o1_valid = 1 holding 0xA5, i_rdy = 0; raise o1_rdy -> o1 takes it and i_rdy = 1 in the same cycle.
REQ-034 Verification: FULL with 0x3C, o0 already taken, o1 fires while i_valid = 1 with 0x7E -> 0x7E is accepted in the same cycle and both branches show 0x7E next cycle.
REQ-035 Verification: assert RST_N = 0 asynchronously (between edges) while 0x55 is pending on o1 -> o1_valid drops immediately; after release 0x55 never appears on either branch.
REQ-036 Verification: random i_valid/o0_rdy/o1_rdy at 50% for 10k cycles -> scoreboard shows each branch's sequence equals the input sequence, no duplicate or lost words, and valid/data stable while stalled.

Source files
------------

// File: rtl/fork2_reg.sv
// fork2_reg: registered one-entry eager fork delivering each word once to two branches
module fork2_reg #(
  parameter int DW = 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [DW-1:0] i_data,
  input  logic          i_valid,
  output logic          i_rdy,
  output logic [DW-1:0] o0_data,
  output logic          o0_valid,
  input  logic          o0_rdy,
  output logic [DW-1:0] o1_data,
  output logic          o1_valid,
  input  logic          o1_rdy
);
  logic [DW-1:0] d_q, d_d;
  logic full_q, full_d, tk0_q, tk0_d, tk1_q, tk1_d;
  logic fire_in, fire0, fire1, done;
  assign o0_valid = full_q & ~tk0_q;
  assign o1_valid = full_q & ~tk1_q;
  assign o0_data  = d_q;
  assign o1_data  = d_q;
  assign fire0    = o0_valid & o0_rdy;
  assign fire1    = o1_valid & o1_rdy;
  assign done     = full_q & (tk0_q | fire0) & (tk1_q | fire1);
  // RST_N gates ready so nothing is accepted while reset is held
  assign i_rdy    = RST_N & (~full_q | done);
  assign fire_in  = i_valid & i_rdy;
  // next state: refill wins over drain, otherwise record branch takes
  always_comb begin
    d_d    = fire_in ? i_data : d_q;
    full_d = fire_in | (full_q & ~done);
    tk0_d  = fire_in | done ? 1'b0 : tk0_q | fire0;
    tk1_d  = fire_in | done ? 1'b0 : tk1_q | fire1;
  end
  // state registers, cleared asynchronously so a pending word is discarded
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      d_q    <= '0;
      full_q <= 1'b0;
      tk0_q  <= 1'b0;
      tk1_q  <= 1'b0;
    end else begin
      d_q    <= d_d;
      full_q <= full_d;
      tk0_q  <= tk0_d;
      tk1_q  <= tk1_d;
    end
  end
endmodule
